// File: rtl/conv_pkg.sv
// Shared types and elaboration helpers for the convolution engine.
package conv_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_MAC   = 2'd1;
    localparam state_t ST_DRAIN = 2'd2;
    localparam state_t ST_DONE  = 2'd3;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

    function automatic int out_n(input int img_n, input int ker_k);
        return img_n - ker_k + 1;
    endfunction

    function automatic int acc_w(input int data_w, input int ker_k);
        return 2 * data_w + clog2(ker_k * ker_k);
    endfunction

    // Index width that never collapses to zero bits for single-entry ranges.
    function automatic int idx_w(input int n);
        return (n > 1) ? clog2(n) : 1;
    endfunction

endpackage

// File: rtl/conv_engine_if.sv
// Start/image/kernel request and result handshake bundle of conv_engine.
interface conv_engine_if #(
    parameter int DATA_W = 8,
    parameter int IMG_N  = 4,
    parameter int KER_K  = 3,
    parameter int OUT_W  = 8
);
    logic                            start;
    logic [IMG_N*IMG_N*DATA_W-1:0]   img_in;
    logic [KER_K*KER_K*DATA_W-1:0]   ker_in;
    logic                            busy;
    logic                            res_valid;
    logic                            res_ready;
    logic [OUT_W-1:0]                res_data;
    logic                            done;

    modport master (
        output start, img_in, ker_in, res_ready,
        input  busy, res_valid, res_data, done
    );

    modport slave (
        input  start, img_in, ker_in, res_ready,
        output busy, res_valid, res_data, done
    );
endinterface

// File: rtl/conv_engine_pe.sv
// One output lane: multiply pixel by broadcast weight, load on the first tap, accumulate after.
module conv_pe #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 20
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en_i,
    input  logic              load_i,
    input  logic [DATA_W-1:0] pix_i,
    input  logic [DATA_W-1:0] w_i,
    output logic [ACC_W-1:0]  acc_o
);
    logic [2*DATA_W-1:0] prod;
    logic [ACC_W-1:0]    acc_q;
    logic [ACC_W-1:0]    acc_d;

    assign prod = pix_i * w_i;

    always_comb begin
        acc_d = acc_q;
        if (en_i) begin
            acc_d = load_i ? ACC_W'(prod) : acc_q + ACC_W'(prod);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc_o = acc_q;
endmodule

// File: rtl/conv_engine.sv
// Row-at-a-time 2-D valid convolution with OUT_N parallel lanes and a drained result stream.
// Optional macro CONV_ENGINE_SAT_EN clamps results to the output range instead of truncating.
module conv_engine
    import conv_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int IMG_N  = 4,
    parameter int KER_K  = 3,
    parameter int OUT_W  = 8
) (
    input  logic         clk,
    input  logic         reset,
    conv_engine_if.slave bus
);
    localparam int OUT_N  = out_n(IMG_N, KER_K);
    localparam int ACC_W  = acc_w(DATA_W, KER_K);
    localparam int IDX_W  = idx_w(IMG_N);
    localparam int KIDX_W = idx_w(KER_K);
    localparam int OIDX_W = idx_w(OUT_N);

    if (KER_K > IMG_N) begin : g_bad_kernel
        $fatal(1, "conv_engine: KER_K must not exceed IMG_N");
    end
    if (OUT_W > ACC_W) begin : g_bad_out_w
        $fatal(1, "conv_engine: OUT_W must not exceed the accumulator width");
    end

    state_t             state_q, state_d;
    logic [OIDX_W-1:0]  row_q, row_d;
    logic [OIDX_W-1:0]  col_q, col_d;
    logic [KIDX_W-1:0]  ti_q, ti_d;
    logic [KIDX_W-1:0]  tj_q, tj_d;
    logic [DATA_W-1:0]  pix_q [IMG_N][IMG_N];
    logic [DATA_W-1:0]  ker_q [KER_K][KER_K];

    logic               start_acc;
    logic               last_tap;
    logic               last_col;
    logic               last_row;

    assign start_acc = (state_q == ST_IDLE) && bus.start;
    assign last_tap  = (ti_q == KIDX_W'(KER_K - 1)) && (tj_q == KIDX_W'(KER_K - 1));
    assign last_col  = (col_q == OIDX_W'(OUT_N - 1));
    assign last_row  = (row_q == OIDX_W'(OUT_N - 1));

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        ti_d    = ti_q;
        tj_d    = tj_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d = ST_MAC;
                    row_d   = '0;
                    col_d   = '0;
                    ti_d    = '0;
                    tj_d    = '0;
                end
            end
            ST_MAC: begin
                if (last_tap) begin
                    state_d = ST_DRAIN;
                    col_d   = '0;
                end else if (tj_q == KIDX_W'(KER_K - 1)) begin
                    tj_d = '0;
                    ti_d = ti_q + 1'b1;
                end else begin
                    tj_d = tj_q + 1'b1;
                end
            end
            ST_DRAIN: begin
                if (bus.res_ready) begin
                    if (!last_col) begin
                        col_d = col_q + 1'b1;
                    end else if (last_row) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_MAC;
                        row_d   = row_q + 1'b1;
                        ti_d    = '0;
                        tj_d    = '0;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            row_q   <= '0;
            col_q   <= '0;
            ti_q    <= '0;
            tj_q    <= '0;
            for (int r = 0; r < IMG_N; r++) begin
                for (int c = 0; c < IMG_N; c++) begin
                    pix_q[r][c] <= '0;
                end
            end
            for (int i = 0; i < KER_K; i++) begin
                for (int j = 0; j < KER_K; j++) begin
                    ker_q[i][j] <= '0;
                end
            end
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            ti_q    <= ti_d;
            tj_q    <= tj_d;
            if (start_acc) begin
                for (int r = 0; r < IMG_N; r++) begin
                    for (int c = 0; c < IMG_N; c++) begin
                        pix_q[r][c] <= bus.img_in[(r*IMG_N+c)*DATA_W +: DATA_W];
                    end
                end
                for (int i = 0; i < KER_K; i++) begin
                    for (int j = 0; j < KER_K; j++) begin
                        ker_q[i][j] <= bus.ker_in[(i*KER_K+j)*DATA_W +: DATA_W];
                    end
                end
            end
        end
    end

    logic               mac_en;
    logic               mac_load;
    logic [DATA_W-1:0]  w_bcast;
    logic [ACC_W-1:0]   acc [OUT_N];

    assign mac_en   = (state_q == ST_MAC);
    assign mac_load = (ti_q == '0) && (tj_q == '0);
    assign w_bcast  = ker_q[ti_q][tj_q];

    for (genvar gi = 0; gi < OUT_N; gi++) begin : g_lane
        logic [DATA_W-1:0] lane_pix;
        // Row and column offsets stay within the image because row < OUT_N and lane < OUT_N.
        assign lane_pix = pix_q[IDX_W'(row_q) + IDX_W'(ti_q)][IDX_W'(tj_q) + IDX_W'(gi)];

        conv_pe #(
            .DATA_W (DATA_W),
            .ACC_W  (ACC_W)
        ) u_pe (
            .clk    (clk),
            .reset  (reset),
            .en_i   (mac_en),
            .load_i (mac_load),
            .pix_i  (lane_pix),
            .w_i    (w_bcast),
            .acc_o  (acc[gi])
        );
    end

    logic [ACC_W-1:0] sel_acc;
    logic [OUT_W-1:0] res_val;

    always_comb begin
        sel_acc = '0;
        for (int c = 0; c < OUT_N; c++) begin
            if (col_q == OIDX_W'(c)) begin
                sel_acc = acc[c];
            end
        end
    end

`ifdef CONV_ENGINE_SAT_EN
    assign res_val = (sel_acc > ACC_W'({OUT_W{1'b1}})) ? {OUT_W{1'b1}} : sel_acc[OUT_W-1:0];
`else
    assign res_val = sel_acc[OUT_W-1:0];
`endif

    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.res_valid = (state_q == ST_DRAIN);
    assign bus.res_data  = bus.res_valid ? res_val : '0;
    assign bus.done      = (state_q == ST_DONE);
endmodule

// File: tb/tb_conv_engine.sv
// Table-driven bench for conv_engine with a result scoreboard and reset/stall/start-while-busy sequences.
module tb_conv_engine;
    localparam int DATA_W    = 8;
    localparam int IMG_N     = 4;
    localparam int KER_K     = 3;
    localparam int OUT_W     = 8;
    localparam int OUT_N     = IMG_N - KER_K + 1;
    localparam int NRES      = OUT_N * OUT_N;
    localparam int IMG_W     = IMG_N * IMG_N * DATA_W;
    localparam int KER_W     = KER_K * KER_K * DATA_W;
    localparam int FIRST_LAT = KER_K * KER_K + 1;
    localparam int RUN_LEN   = OUT_N * (KER_K * KER_K + OUT_N) + 2;
    localparam int NVEC      = 6;

    typedef struct packed {
        logic [IMG_W-1:0]             img;
        logic [KER_W-1:0]             ker;
        logic [7:0]                   stall;
        logic                         poke;
        logic [NRES-1:0][OUT_W-1:0]   exp;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    conv_engine_if #(.DATA_W(DATA_W), .IMG_N(IMG_N), .KER_K(KER_K), .OUT_W(OUT_W)) bus ();

    conv_engine #(.DATA_W(DATA_W), .IMG_N(IMG_N), .KER_K(KER_K), .OUT_W(OUT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int               n_cmp = 0;
    int               n_err = 0;
    int               n_txn = 0;
    logic [OUT_W-1:0] sb_q [$];
    vec_t             vecs [NVEC];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [IMG_W-1:0] img_const(input int v);
        logic [IMG_W-1:0] img;
        for (int k = 0; k < IMG_N*IMG_N; k++) img[k*DATA_W +: DATA_W] = DATA_W'(v);
        return img;
    endfunction

    function automatic logic [KER_W-1:0] ker_const(input int v);
        logic [KER_W-1:0] ker;
        for (int k = 0; k < KER_K*KER_K; k++) ker[k*DATA_W +: DATA_W] = DATA_W'(v);
        return ker;
    endfunction

    function automatic logic [IMG_W-1:0] img_ramp();
        logic [IMG_W-1:0] img;
        for (int r = 0; r < IMG_N; r++)
            for (int c = 0; c < IMG_N; c++)
                img[(r*IMG_N+c)*DATA_W +: DATA_W] = DATA_W'(4*r + c);
        return img;
    endfunction

    function automatic logic [IMG_W-1:0] img_rand();
        logic [IMG_W-1:0] img;
        for (int k = 0; k < IMG_N*IMG_N; k++) img[k*DATA_W +: DATA_W] = DATA_W'($urandom_range(0, 255));
        return img;
    endfunction

    function automatic logic [KER_W-1:0] ker_rand();
        logic [KER_W-1:0] ker;
        for (int k = 0; k < KER_K*KER_K; k++) ker[k*DATA_W +: DATA_W] = DATA_W'($urandom_range(0, 15));
        return ker;
    endfunction

    // Plain sum-of-products reference for output pixel (r,c).
    function automatic logic [OUT_W-1:0] model(input logic [IMG_W-1:0] img, input logic [KER_W-1:0] ker,
                                               input int r, input int c);
        int unsigned sum;
        int unsigned p;
        int unsigned w;
        sum = 0;
        for (int i = 0; i < KER_K; i++) begin
            for (int j = 0; j < KER_K; j++) begin
                p = 32'(img[((r+i)*IMG_N + c + j)*DATA_W +: DATA_W]);
                w = 32'(ker[(i*KER_K + j)*DATA_W +: DATA_W]);
                sum += p * w;
            end
        end
`ifdef CONV_ENGINE_SAT_EN
        if (sum > (2**OUT_W - 1)) return {OUT_W{1'b1}};
`endif
        return OUT_W'(sum);
    endfunction

    function automatic vec_t mk_model_vec(input logic [IMG_W-1:0] img, input logic [KER_W-1:0] ker,
                                          input int stall, input logic poke);
        vec_t v;
        v.img   = img;
        v.ker   = ker;
        v.stall = 8'(stall);
        v.poke  = poke;
        for (int r = 0; r < OUT_N; r++)
            for (int c = 0; c < OUT_N; c++)
                v.exp[r*OUT_N + c] = model(img, ker, r, c);
        return v;
    endfunction

    task automatic run_vec(input vec_t v, input string tag);
        int               cyc;
        int               first_v;
        int               last_hs;
        int               done_cyc;
        int               n_done;
        int               stall_left;
        int               bad_zero;
        logic [OUT_W-1:0] held;
        logic [OUT_W-1:0] e;

        for (int k = 0; k < NRES; k++) sb_q.push_back(v.exp[k]);
        first_v    = -1;
        last_hs    = -1;
        done_cyc   = -1;
        n_done     = 0;
        bad_zero   = 0;
        stall_left = int'(v.stall);
        held       = '0;

        bus.start     = 1'b1;
        bus.img_in    = v.img;
        bus.ker_in    = v.ker;
        bus.res_ready = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        cyc = 1;
        while (1) begin
            bus.start = 1'b0;
            if (bus.res_valid && first_v < 0) begin
                first_v = cyc;
                held    = bus.res_data;
            end
            if (bus.res_valid && stall_left > 0) begin
                bus.res_ready = 1'b0;
                check({tag, " stall_hold"}, 64'(bus.res_data), 64'(held));
                stall_left--;
            end else begin
                bus.res_ready = 1'b1;
            end
            if (bus.res_valid && bus.res_ready) begin
                if (sb_q.size() == 0) begin
                    check({tag, " extra_result"}, 64'(1), 64'(0));
                end else begin
                    e = sb_q.pop_front();
                    $display("txn %0d [%s] cycle %0d: res_data=%0d expected=%0d", n_txn, tag, cyc, bus.res_data, e);
                    n_txn++;
                    check({tag, " res_data"}, 64'(bus.res_data), 64'(e));
                end
                last_hs = cyc;
            end
            if (!bus.res_valid && bus.res_data != '0) bad_zero++;
            if (bus.done) begin
                n_done++;
                done_cyc = cyc;
                // Start during DONE must not retrigger.
                if (v.poke) bus.start = 1'b1;
            end
            if (!bus.busy) break;
            if (v.poke && cyc == 3) begin
                bus.start  = 1'b1;
                bus.img_in = ~v.img;
                bus.ker_in = ~v.ker;
            end
            @(posedge clk); #1;
            cyc++;
            if (cyc > 400) begin
                check({tag, " timeout"}, 64'(cyc), 64'(RUN_LEN));
                break;
            end
        end
        bus.start     = 1'b0;
        bus.res_ready = 1'b1;

        check({tag, " first_valid_latency"}, 64'(first_v), 64'(FIRST_LAT));
        check({tag, " run_length"}, 64'(cyc), 64'(RUN_LEN + int'(v.stall)));
        check({tag, " done_count"}, 64'(n_done), 64'(1));
        check({tag, " done_after_last_hs"}, 64'(done_cyc), 64'(last_hs + 1));
        check({tag, " missing_results"}, 64'(sb_q.size()), 64'(0));
        check({tag, " data_zero_when_invalid"}, 64'(bad_zero), 64'(0));
        sb_q.delete();
        @(posedge clk); #1;
        check({tag, " idle_after_done"}, 64'(bus.busy), 64'(0));
    endtask

    initial begin
        int seen_valid;
        int seen_done;

        reset         = 1'b1;
        bus.start     = 1'b0;
        bus.img_in    = '0;
        bus.ker_in    = '0;
        bus.res_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset busy", 64'(bus.busy), 64'(0));
        check("reset res_valid", 64'(bus.res_valid), 64'(0));
        check("reset res_data", 64'(bus.res_data), 64'(0));
        check("reset done", 64'(bus.done), 64'(0));
        reset = 1'b0;
        @(posedge clk); #1;

        vecs[0].img = img_const(1);  vecs[0].ker = ker_const(1);
        vecs[0].stall = 8'd0;        vecs[0].poke = 1'b0;
        for (int k = 0; k < NRES; k++) vecs[0].exp[k] = OUT_W'(9);

        vecs[1].img = img_ramp();    vecs[1].ker = '0;
        vecs[1].ker[(1*KER_K+1)*DATA_W +: DATA_W] = DATA_W'(1);
        vecs[1].stall = 8'd0;        vecs[1].poke = 1'b0;
        vecs[1].exp[0] = OUT_W'(5);  vecs[1].exp[1] = OUT_W'(6);
        vecs[1].exp[2] = OUT_W'(9);  vecs[1].exp[3] = OUT_W'(10);

        vecs[2] = vecs[0];
        vecs[2].stall = 8'd5;

        vecs[3].img = img_const(255); vecs[3].ker = ker_const(255);
        vecs[3].stall = 8'd0;         vecs[3].poke = 1'b0;
`ifdef CONV_ENGINE_SAT_EN
        for (int k = 0; k < NRES; k++) vecs[3].exp[k] = OUT_W'(255);
`else
        for (int k = 0; k < NRES; k++) vecs[3].exp[k] = OUT_W'(9);
`endif

        vecs[4] = mk_model_vec(img_rand(), ker_rand(), 0, 1'b1);
        vecs[5] = mk_model_vec(img_rand(), ker_rand(), 2, 1'b0);

        for (int n = 0; n < NVEC; n++) begin
            run_vec(vecs[n], $sformatf("vec%0d", n));
        end

        // Abort during row 1 accumulation, then confirm silence and a clean restart.
        bus.start     = 1'b1;
        bus.img_in    = img_const(1);
        bus.ker_in    = ker_const(1);
        bus.res_ready = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (13) begin
            @(posedge clk); #1;
        end
        check("abort pre-reset busy", 64'(bus.busy), 64'(1));
        check("abort pre-reset in MAC", 64'(bus.res_valid), 64'(0));
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("abort busy", 64'(bus.busy), 64'(0));
        check("abort res_valid", 64'(bus.res_valid), 64'(0));
        check("abort res_data", 64'(bus.res_data), 64'(0));
        check("abort done", 64'(bus.done), 64'(0));
        seen_valid = 0;
        seen_done  = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.res_valid) seen_valid++;
            if (bus.done) seen_done++;
        end
        check("abort no results", 64'(seen_valid), 64'(0));
        check("abort no done", 64'(seen_done), 64'(0));
        run_vec(vecs[1], "after_abort");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
